// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter and hardware call/return stack for the small CPU core.
// Drives the instruction-memory fetch address every cycle. It also handles start/stall
// sequencing and holds a sticky fault state when the return stack overflows or underflows.
module pc_sequencer #(
    parameter int PC_WIDTH    = 5,
    parameter int STACK_DEPTH = 8,
    parameter int SP_WIDTH    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stall,
    input  logic                jmp,
    input  logic                cal,
    input  logic                ret,
    input  logic [PC_WIDTH-1:0] jmp_addr,
    output logic [PC_WIDTH-1:0] pc,
    output logic                running,
    output logic [SP_WIDTH-1:0] sp,
    output logic                overflow,
    output logic                underflow,
    output logic                fault
);

    localparam int AW = $clog2(STACK_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [PC_WIDTH-1:0]   pc_nxt;
    logic [SP_WIDTH-1:0]   sp_nxt;
    logic                  ovf_nxt, udf_nxt;
    logic                  push;
    logic [PC_WIDTH-1:0]   pc_inc;
    logic [AW-1:0]         wr_idx, rd_idx;
    logic                  stack_full, stack_empty;

    // Return-address storage. It has no reset because its contents only matter below sp.
    logic [PC_WIDTH-1:0]   stack [STACK_DEPTH];

    assign pc_inc      = pc + PC_WIDTH'(1);
    assign stack_full  = (sp == SP_WIDTH'(STACK_DEPTH));
    assign stack_empty = (sp == '0);
    // A push only happens when sp < STACK_DEPTH, so the low bits index directly.
    assign wr_idx      = sp[AW-1:0];
    assign rd_idx      = AW'(sp - SP_WIDTH'(1));

    assign running = (state == S_RUN);
    assign fault   = (state == S_FAULT);

    // Next-state and datapath decode: at most one action per edge, priority ret > cal > jmp > step.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        sp_nxt    = sp;
        ovf_nxt   = overflow;
        udf_nxt   = underflow;
        push      = 1'b0;
        unique case (state)
            S_IDLE: begin
                pc_nxt = '0;
                if (start) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (!stall) begin
                    if (ret) begin
                        if (stack_empty) begin
                            udf_nxt   = 1'b1;
                            state_nxt = S_FAULT;
                        end else begin
                            pc_nxt = stack[rd_idx];
                            sp_nxt = sp - SP_WIDTH'(1);
                        end
                    end else if (cal) begin
                        if (stack_full) begin
                            ovf_nxt   = 1'b1;
                            state_nxt = S_FAULT;
                        end else begin
                            push   = 1'b1;
                            sp_nxt = sp + SP_WIDTH'(1);
                            pc_nxt = jmp_addr;
                        end
                    end else if (jmp) begin
                        pc_nxt = jmp_addr;
                    end else begin
                        pc_nxt = pc_inc;
                    end
                end
            end
            S_FAULT: begin
                // Frozen until reset.
            end
            default: begin
                state_nxt = S_IDLE;
                pc_nxt    = '0;
            end
        endcase
    end

    // State, pc, sp and sticky flags. A reset overrides every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            pc        <= '0;
            sp        <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            sp        <= sp_nxt;
            overflow  <= ovf_nxt;
            underflow <= udf_nxt;
        end
    end

    // Push the return address (pc+1, wrapping) on a successful call. Reset suppresses the push.
    always_ff @(posedge clk) begin
        if (push && !rst) stack[wr_idx] <= pc_inc;
    end

endmodule
